uart_ahb_loader: RTL and testbench

AHB-Lite master that loads program/data images into memory from a byte stream delivered by the UART receive path. It parses a framed stream (sync, base address, word count, payload words, optional checksum) and issues one single-beat 32-bit AHB-Lite write per payload word onto the data-side bus, where the address decoder routes it to the cached BRAM or any other slave. It also holds the CPU in reset while a frame is in progress.

---
 rtl/uart_ahb_loader.sv | 188 ++++++++++++++++++
 tb/tb_uart_ahb_loader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ahb_loader.sv
// Frame loader: parses a UART byte stream (sync, base, count, payload) into single-beat AHB-Lite writes.
// Optional trailing XOR checksum byte is enabled with LOADER_CHECKSUM_EN.
module uart_ahb_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [31:0] ADDR_LO   = 32'h1c000000,
  parameter logic [31:0] ADDR_HI   = 32'h1c060000
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        core_hold_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] words_o
);

  localparam logic [2:0] S_SYNC  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LEN   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_AHB_A = 3'd4;
  localparam logic [2:0] S_AHB_D = 3'd5;
  localparam logic [2:0] S_CSUM  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_END = S_CSUM;
`else
  localparam logic [2:0] S_END = S_DONE;
`endif

  logic [2:0]  state;
  logic [1:0]  bidx;
  logic [31:0] cur;
  logic [15:0] rem;
  logic [31:0] word;
  logic [15:0] words;
  logic        err;

  logic        accept;
  logic        in_range;
  logic        nonseq;
  logic [31:0] next_cur;
  logic [15:0] next_rem;
  logic [31:0] next_word;

  assign accept    = rx_valid_i && rx_ready_o;
  assign in_range  = (cur >= ADDR_LO) && (cur < ADDR_HI);
  // Little-endian assembly: each byte enters at the top, so the first byte ends up in bits [7:0].
  assign next_cur  = {rx_data_i, cur[31:8]};
  assign next_rem  = {rx_data_i, rem[15:8]};
  assign next_word = {rx_data_i, word[31:8]};

  // Reset gates the bus request combinationally so an aborted frame releases the bus at once.
  assign nonseq      = !reset && (state == S_AHB_A) && in_range;
  assign HTRANS      = nonseq ? 2'b10 : 2'b00;
  assign HWRITE      = nonseq;
  assign HADDR       = cur;
  assign HWDATA      = word;
  assign HSIZE       = 3'b010;
  assign HBURST      = 3'b000;
  assign HPROT       = 4'b0011;
  assign HMASTLOCK   = 1'b0;

  assign rx_ready_o  = !reset && ((state == S_SYNC) || (state == S_ADDR) || (state == S_LEN) ||
                                  (state == S_DATA) || (state == S_CSUM));
  assign core_hold_o = !reset && (state != S_SYNC) && (state != S_DONE);
  assign done_o      = (state == S_DONE);
  assign err_o       = err;
  assign words_o     = words;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      csum <= '0;
    end else if (accept) begin
      csum <= (state == S_SYNC) ? '0 : (csum ^ rx_data_i);
    end
  end
`endif

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state <= S_SYNC;
      bidx  <= '0;
      cur   <= '0;
      rem   <= '0;
      word  <= '0;
      words <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_SYNC: begin
          if (accept && (rx_data_i == SYNC_BYTE)) begin
            state <= S_ADDR;
            err   <= 1'b0;
            words <= '0;
            bidx  <= '0;
          end
        end
        S_ADDR: begin
          if (accept) begin
            cur  <= next_cur;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              if (next_cur[1:0] != 2'b00) begin
                err   <= 1'b1;
                state <= S_SYNC;
              end else begin
                state <= S_LEN;
              end
            end
          end
        end
        S_LEN: begin
          if (accept) begin
            rem  <= next_rem;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd1) begin
              bidx  <= '0;
              state <= (next_rem == '0) ? S_END : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            word <= next_word;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) state <= S_AHB_A;
          end
        end
        S_AHB_A: begin
          // Out-of-window words are consumed without a bus transfer.
          if (!in_range) begin
            err   <= 1'b1;
            cur   <= cur + 32'd4;
            rem   <= rem - 16'd1;
            state <= (rem == 16'd1) ? S_END : S_DATA;
          end else if (HREADY) begin
            state <= S_AHB_D;
          end
        end
        S_AHB_D: begin
          if (HREADY) begin
            if (HRESP) begin
              err   <= 1'b1;
              state <= S_SYNC;
            end else begin
              words <= words + 16'd1;
              cur   <= cur + 32'd4;
              rem   <= rem - 16'd1;
              state <= (rem == 16'd1) ? S_END : S_DATA;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (rx_data_i == csum) begin
              state <= S_DONE;
            end else begin
              err   <= 1'b1;
              state <= S_SYNC;
            end
          end
        end
`endif
        S_DONE:  state <= S_SYNC;
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ahb_loader.sv
// Scoreboard bench for uart_ahb_loader: stimulus pushes expected writes, a bus monitor pops and compares.
module tb_uart_ahb_loader;
  logic        sys_clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic        core_hold_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] words_o;

  always #5 sys_clock = ~sys_clock;

  uart_ahb_loader dut (
    .sys_clock(sys_clock), .reset(reset),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .core_hold_o(core_hold_o), .done_o(done_o), .err_o(err_o), .words_o(words_o)
  );

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model: wait_n wait states per phase, HRESP on the data phase numbered resp_at.
  int   wait_n = 0;
  int   wcnt = 0;
  int   dphase_idx = 0;
  int   resp_at = -1;
  logic dphase = 1'b0;

  assign HREADY = !((HTRANS == 2'b10) || dphase) || (wcnt >= wait_n);
  assign HRESP  = dphase && (dphase_idx == resp_at);

  always @(posedge sys_clock) begin
    if (reset) begin
      dphase <= 1'b0;
      wcnt   <= 0;
    end else if (HREADY) begin
      if (dphase) dphase_idx <= dphase_idx + 1;
      dphase <= (HTRANS == 2'b10);
      wcnt   <= 0;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  // Monitor: samples on the falling edge, checks hold-stability and completed writes.
  logic [31:0] a_hold, d_hold, addr_q;
  bit          a_valid = 0, d_valid = 0;
  int          nonseq_seen = 0;
  int          done_cnt = 0;
  wr_t         e;

  always @(negedge sys_clock) begin
    if (reset) begin
      a_valid = 0;
      d_valid = 0;
    end else begin
      if (done_o) done_cnt++;
      if (dphase) begin
        if (!d_valid) begin
          d_hold  = HWDATA;
          d_valid = 1;
        end else check("hwdata_stable", HWDATA, d_hold);
        if (HREADY) begin
          d_valid = 0;
          if (!HRESP) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_write: got %h @ %h expected none", HWDATA, addr_q);
            end else begin
              e = sb.pop_front();
              check("wr_addr", addr_q, e.a);
              check("wr_data", HWDATA, e.d);
            end
          end
        end
      end
      if (HTRANS == 2'b10) begin
        nonseq_seen++;
        if (!a_valid) begin
          a_hold  = HADDR;
          a_valid = 1;
        end else check("haddr_stable", HADDR, a_hold);
        if (HREADY) begin
          addr_q  = a_hold;
          a_valid = 0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && t < 200) begin
      @(posedge sys_clock); #1;
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_timeout: got ready=0 expected ready=1");
    end
    @(posedge sys_clock); #1;
    rx_valid_i = 1'b0;
  endtask

`ifdef LOADER_CHECKSUM_EN
  bit bad_csum = 0;
`endif

  task automatic send_frame(input logic [31:0] base, input logic [15:0] n,
                            input logic [31:0] w0, input logic [31:0] w1);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] wd;
    cs = '0;
    send_byte(8'hA5);
    check("hold_after_sync", {31'b0, core_hold_o}, 32'd1);
    check("err_clear_on_sync", {31'b0, err_o}, 32'd0);
    check("words_clear_on_sync", {16'b0, words_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin b = base[8*i +: 8]; cs ^= b; send_byte(b); end
    for (int i = 0; i < 2; i++) begin b = n[8*i +: 8]; cs ^= b; send_byte(b); end
    for (int k = 0; k < int'(n); k++) begin
      wd = (k == 0) ? w0 : w1;
      for (int i = 0; i < 4; i++) begin b = wd[8*i +: 8]; cs ^= b; send_byte(b); end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_csum ? ~cs : cs);
`endif
  endtask

  task automatic wait_idle();
    int t = 0;
    while (core_hold_o && t < 1000) begin
      @(posedge sys_clock); #1;
      t++;
    end
    if (t >= 1000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got core_hold=1 expected 0");
    end
    repeat (2) @(posedge sys_clock);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    sb.push_back(w);
  endtask

  task automatic check_end(input string tag, input logic err_exp, input logic [15:0] words_exp,
                           input int done_exp, input int done_before);
    check({tag, "_err"}, {31'b0, err_o}, {31'b0, err_exp});
    check({tag, "_words"}, {16'b0, words_o}, {16'b0, words_exp});
    check({tag, "_done_pulses"}, done_cnt - done_before, done_exp);
    check({tag, "_hold"}, {31'b0, core_hold_o}, 32'd0);
    check({tag, "_sb_drained"}, sb.size(), 32'd0);
  endtask

  int d0, ns0;
  logic [7:0] mis [4];

  initial begin
    reset      = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = '0;
    repeat (2) @(posedge sys_clock);
    #1;
    check("rst_rx_ready", {31'b0, rx_ready_o}, 32'd0);
    check("rst_htrans", {30'b0, HTRANS}, 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_hwrite", {31'b0, HWRITE}, 32'd0);
    check("rst_hold", {31'b0, core_hold_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_words", {16'b0, words_o}, 32'd0);
    reset = 1'b0;
    @(posedge sys_clock); #1;
    check("sync_rx_ready", {31'b0, rx_ready_o}, 32'd1);

    // Basic two-word frame, zero-wait slave
    d0 = done_cnt;
    push(32'h1c010000, 32'h44332211);
    push(32'h1c010004, 32'h88776655);
    send_frame(32'h1c010000, 16'd2, 32'h44332211, 32'h88776655);
    wait_idle();
    check_end("frameA", 1'b0, 16'd2, 1, d0);

    // Same frame with three wait states per phase
    wait_n = 3;
    d0 = done_cnt;
    push(32'h1c010000, 32'h44332211);
    push(32'h1c010004, 32'h88776655);
    send_frame(32'h1c010000, 16'd2, 32'h44332211, 32'h88776655);
    wait_idle();
    check_end("frameA_wait", 1'b0, 16'd2, 1, d0);
    wait_n = 0;

    // Misaligned base: aborted before any bus transfer
    d0  = done_cnt;
    ns0 = nonseq_seen;
    mis[0] = 8'h02; mis[1] = 8'h00; mis[2] = 8'h01; mis[3] = 8'h1c;
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(mis[i]);
    check("misalign_hold_drop", {31'b0, core_hold_o}, 32'd0);
    wait_idle();
    check_end("misalign", 1'b1, 16'd0, 0, d0);
    check("misalign_no_nonseq", nonseq_seen - ns0, 32'd0);

    // Recovery frame clears the sticky error
    d0 = done_cnt;
    push(32'h1c010000, 32'h44332211);
    push(32'h1c010004, 32'h88776655);
    send_frame(32'h1c010000, 16'd2, 32'h44332211, 32'h88776655);
    wait_idle();
    check_end("recover", 1'b0, 16'd2, 1, d0);

    // Slave error on the first data phase
    d0 = done_cnt;
    resp_at = dphase_idx;
    send_frame(32'h1c010000, 16'd2, 32'h44332211, 32'h88776655);
    wait_idle();
    check_end("hresp", 1'b1, 16'd0, 0, d0);
    resp_at = -1;

    // Window boundary: second word lands on ADDR_HI and is skipped
    push(32'h1c05fffc, 32'hdeadbeef);
    send_frame(32'h1c05fffc, 16'd2, 32'hdeadbeef, 32'h01020304);
    wait_idle();
    check("bound_err", {31'b0, err_o}, 32'd1);
    check("bound_words", {16'b0, words_o}, 32'd1);
    check("bound_sb_drained", sb.size(), 32'd0);

    // Empty frame at ADDR_LO
    d0 = done_cnt;
    send_frame(32'h1c000000, 16'd0, 32'h0, 32'h0);
    wait_idle();
    check_end("empty", 1'b0, 16'd0, 1, d0);

`ifdef LOADER_CHECKSUM_EN
    // Corrupted checksum: writes happen, frame ends in error without done
    d0 = done_cnt;
    bad_csum = 1;
    push(32'h1c010000, 32'h44332211);
    push(32'h1c010004, 32'h88776655);
    send_frame(32'h1c010000, 16'd2, 32'h44332211, 32'h88776655);
    wait_idle();
    check_end("bad_csum", 1'b1, 16'd2, 0, d0);
    bad_csum = 0;
`endif

    // Reset while a write is stalled in its address phase
    wait_n = 3;
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h1c);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hef); send_byte(8'hbe); send_byte(8'had); send_byte(8'hde);
    check("mid_nonseq", {30'b0, HTRANS}, 32'h2);
    reset = 1'b1;
    #1;
    check("mid_rst_htrans", {30'b0, HTRANS}, 32'd0);
    check("mid_rst_hold", {31'b0, core_hold_o}, 32'd0);
    check("mid_rst_rx_ready", {31'b0, rx_ready_o}, 32'd0);
    @(posedge sys_clock); #1;
    check("mid_rst_haddr", HADDR, 32'd0);
    check("mid_rst_hwdata", HWDATA, 32'd0);
    check("mid_rst_hwrite", {31'b0, HWRITE}, 32'd0);
    check("mid_rst_words", {16'b0, words_o}, 32'd0);
    check("mid_rst_err", {31'b0, err_o}, 32'd0);
    check("mid_rst_done", {31'b0, done_o}, 32'd0);
    reset = 1'b0;
    @(posedge sys_clock); #1;
    check("mid_rst_sync", {31'b0, rx_ready_o}, 32'd1);
    wait_n = 0;

    // Frame after reset completes normally
    d0 = done_cnt;
    push(32'h1c020000, 32'hcafef00d);
    send_frame(32'h1c020000, 16'd1, 32'hcafef00d, 32'h0);
    wait_idle();
    check_end("post_rst", 1'b0, 16'd1, 1, d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
